alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port ALUOp  input  4  operation select, sampled with start.
REQ-006 SHALL have ports A, B  input  WIDTH  operands, sampled with start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-009 SHALL have port alu_res  output  WIDTH  main result (mul low half / quotient).
REQ-010 SHALL have port alu_hi  output  WIDTH  mul high half / remainder; 0 for other ops.
REQ-011 SHALL have ports zero, overflow, condition_jdg, div_by_zero  output  1 each  status flags.

Function
REQ-012 SHALL encode ALUOp: 0000 add, 0001 sub, 0010 or, 0011 slt (signed), 0100 addi (with overflow), 0101 bgezal, 0110 and, 0111 xor, 1000 sltu, 1001 mulu, 1010 divu; 1011-1111 illegal.
REQ-013 SHALL use FSM states IDLE, CALC, DONE; IDLE->DONE on start with single-cycle op, illegal op, or divu with B==0; IDLE->CALC on start with mulu/divu (B!=0); CALC->DONE after WIDTH iteration cycles; DONE->IDLE unconditionally.
REQ-014 SHALL assert done exactly in DONE state; latency start-to-done = 1 cycle single-cycle ops, WIDTH+1 cycles mulu/divu.
REQ-015 SHALL assert busy in CALC and DONE; start while busy SHALL be ignored (no queueing).
REQ-016 SHALL compute add/addi/sub modulo 2^WIDTH; slt/sltu result 1 or 0 zero-extended.
REQ-017 SHALL set overflow only for addi, = signed overflow of A+B (operand signs equal, result sign differs); 0 otherwise.
REQ-018 SHALL set condition_jdg only for bgezal, = ($signed A >= 0); bgezal alu_res = 0.
REQ-019 SHALL set zero = (A == B) on sampled operands, for every opcode.
REQ-020 SHALL implement mulu as unsigned shift-add, one bit per CALC cycle; {alu_hi, alu_res} = full 2*WIDTH product.
REQ-021 SHALL implement divu as unsigned restoring division, one bit per CALC cycle; alu_res = quotient, alu_hi = remainder.
REQ-022 SHALL for divu with B==0: alu_res = all ones, alu_hi = A, div_by_zero = 1; div_by_zero 0 for all other cases.
REQ-023 SHALL for illegal opcode: alu_res = 0, alu_hi = 0, all flags 0, done still pulsed.
REQ-024 SHALL hold all result/flag outputs stable from done until the next done; update only in DONE.
REQ-025 SHALL use internal operand copies so A/B/ALUOp changes during CALC do not affect the result.
REQ-026 SHALL handle start and done in same cycle: start ignored (FSM not in IDLE).

Reset
REQ-027 SHALL on rst high at a clock edge: state IDLE, busy 0, done 0, alu_res 0, alu_hi 0, all flags 0, iteration counter 0.
REQ-028 SHALL give rst priority over start and over an in-progress CALC (operation abandoned, no done).
REQ-029 SHALL accept a new start in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover addi WIDTH=32: A=0x7FFFFFFF, B=1 -> done 1 cycle later, alu_res=0x80000000, overflow=1, zero=0.
REQ-031 SHALL cover mulu WIDTH=32: A=0xFFFFFFFF, B=0xFFFFFFFF -> done at cycle 33, alu_hi=0xFFFFFFFE, alu_res=0x00000001; busy high cycles 1-33.
REQ-032 SHALL cover divu: A=100, B=7 -> alu_res=14, alu_hi=2 after 33 cycles; then A=5, B=0 -> 1 cycle, alu_res=0xFFFFFFFF, alu_hi=5, div_by_zero=1.
REQ-033 SHALL cover rst asserted mid-mulu (cycle 10) -> next cycle busy=0, outputs 0, no done pulse; new slt A=-1, B=1 -> alu_res=1.
REQ-034 SHALL cover start held high during divu with changing A/B -> single done, result of originally sampled operands; bgezal A=0 -> condition_jdg=1.
REQ-035 SHALL cover WIDTH=8 mulu A=0xFF, B=0x02 -> done at cycle 9, alu_hi=0x01, alu_res=0xFE; illegal op 1111 -> done, all outputs 0.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops complete in one cycle,
// unsigned multiply (shift-add) and divide (restoring) take WIDTH cycles.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] alu_hi,
    output logic             zero,
    output logic             overflow,
    output logic             condition_jdg,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0010;
    localparam logic [3:0] OP_SLT    = 4'b0011;
    localparam logic [3:0] OP_ADDI   = 4'b0100;
    localparam logic [3:0] OP_BGEZAL = 4'b0101;
    localparam logic [3:0] OP_AND    = 4'b0110;
    localparam logic [3:0] OP_XOR    = 4'b0111;
    localparam logic [3:0] OP_SLTU   = 4'b1000;
    localparam logic [3:0] OP_MULU   = 4'b1001;
    localparam logic [3:0] OP_DIVU   = 4'b1010;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    // Iteration registers shared by multiply and divide.
    logic             mul_q;    // 1: multiply in progress, 0: divide
    logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
    logic [WIDTH-1:0] hi_q;     // partial product high half or remainder
    logic [WIDTH-1:0] lo_q;     // multiplier/product low half or dividend/quotient
    logic             zero_q;   // A == B captured at start
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_zero, sc_ovf, sc_cond, sc_dbz;
    logic [WIDTH-1:0] add_sum;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             last_iter;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign add_sum   = A + B;

    // Single-cycle results and flags straight from the live operands.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sc_res  = '0;
        sc_hi   = '0;
        sc_zero = (A == B);
        sc_ovf  = 1'b0;
        sc_cond = 1'b0;
        sc_dbz  = 1'b0;
        case (ALUOp)
            OP_ADD:    sc_res = add_sum;
            OP_SUB:    sc_res = A - B;
            OP_OR:     sc_res = A | B;
            OP_SLT:    sc_res = WIDTH'($signed(A) < $signed(B));
            OP_ADDI: begin
                sc_res = add_sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_BGEZAL: sc_cond = ~A[WIDTH-1];
            OP_AND:    sc_res = A & B;
            OP_XOR:    sc_res = A ^ B;
            OP_SLTU:   sc_res = WIDTH'(A < B);
            OP_MULU:   ;
            OP_DIVU: begin
                if (B == '0) begin
                    sc_res = '1;
                    sc_hi  = A;
                    sc_dbz = 1'b1;
                end
            end
            default:   sc_zero = 1'b0;   // illegal opcode: everything reads 0
        endcase
    end

    // One shift-add or restoring-divide step on the iteration registers.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (mul_q) begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH+1]) begin
            it_hi = div_shift[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
            it_hi = div_diff[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((ALUOp == OP_MULU) || ((ALUOp == OP_DIVU) && (B != '0)))
                        state_nx = CALC;
                    else
                        state_nx = DONE;
                end
            end
            CALC:    if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand capture, iteration, and result registers (written only on entry to DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_q         <= 1'b0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            zero_q        <= 1'b0;
            cnt           <= '0;
            alu_res       <= '0;
            alu_hi        <= '0;
            zero          <= 1'b0;
            overflow      <= 1'b0;
            condition_jdg <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (state_nx == CALC) begin
                            mul_q  <= (ALUOp == OP_MULU);
                            opnd_q <= (ALUOp == OP_MULU) ? A : B;
                            lo_q   <= (ALUOp == OP_MULU) ? B : A;
                            hi_q   <= '0;
                            zero_q <= (A == B);
                            cnt    <= '0;
                        end else begin
                            alu_res       <= sc_res;
                            alu_hi        <= sc_hi;
                            zero          <= sc_zero;
                            overflow      <= sc_ovf;
                            condition_jdg <= sc_cond;
                            div_by_zero   <= sc_dbz;
                        end
                    end
                end
                CALC: begin
                    hi_q <= it_hi;
                    lo_q <= it_lo;
                    cnt  <= cnt + CW'(1);
                    if (last_iter) begin
                        alu_res       <= it_lo;
                        alu_hi        <= it_hi;
                        zero          <= zero_q;
                        overflow      <= 1'b0;
                        condition_jdg <= 1'b0;
                        div_by_zero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: a 32-bit and an 8-bit instance, a table
// of directed vectors, hand-written multi-cycle sequences and random ops
// compared against an arithmetic reference model.
module tb_alu_mc;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        zero;
        logic        ovf;
        logic        cond;
        logic        dbz;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        int          w;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [3:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;

    logic        busy32, done32, z32, ov32, cj32, dz32;
    logic [31:0] res32, hi32;
    logic        busy8, done8, z8, ov8, cj8, dz8;
    logic [7:0]  res8, hi8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .ALUOp(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .alu_res(res32), .alu_hi(hi32),
        .zero(z32), .overflow(ov32), .condition_jdg(cj32), .div_by_zero(dz32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ALUOp(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .alu_res(res8), .alu_hi(hi8),
        .zero(z8), .overflow(ov8), .condition_jdg(cj8), .div_by_zero(dz8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the operation rules in plain integer arithmetic.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] m, p;
        longint sa, sb, s, lim;
        m   = (64'd1 << w) - 64'd1;
        sa  = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb  = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        lim = longint'(64'd1 << (w - 1));
        e.res = '0; e.hi = '0; e.zero = (a == b);
        e.ovf = 1'b0; e.cond = 1'b0; e.dbz = 1'b0; e.lat = 1;
        case (op)
            4'd0:  e.res = (a + b) & m;
            4'd1:  e.res = (a - b) & m;
            4'd2:  e.res = a | b;
            4'd3:  e.res = (sa < sb) ? 64'd1 : 64'd0;
            4'd4: begin
                e.res = (a + b) & m;
                s     = sa + sb;
                e.ovf = (s >= lim) || (s < -lim);
            end
            4'd5:  e.cond = (sa >= 0);
            4'd6:  e.res = a & b;
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = (a < b) ? 64'd1 : 64'd0;
            4'd9: begin
                p     = a * b;
                e.res = p & m;
                e.hi  = (p >> w) & m;
                e.lat = w + 1;
            end
            4'd10: begin
                if (b == 0) begin
                    e.res = m; e.hi = a; e.dbz = 1'b1;
                end else begin
                    e.res = a / b; e.hi = a % b; e.lat = w + 1;
                end
            end
            default: e.zero = 1'b0;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input string n, input int w, input logic [3:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] res, input logic [63:0] hi,
                                input logic z, input logic o, input logic c,
                                input logic d, input int lat);
        vec_t v;
        v.name = n; v.w = w; v.op = op; v.a = a; v.b = b;
        v.e.res = res; v.e.hi = hi; v.e.zero = z; v.e.ovf = o;
        v.e.cond = c; v.e.dbz = d; v.e.lat = lat;
        return v;
    endfunction

    task automatic drive(input int w, input logic s, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            start32 = s; op32 = op; a32 = a[31:0]; b32 = b[31:0];
        end else begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic sample(input int w, output exp_t o, output logic bsy, output logic dn);
        if (w == 32) begin
            o.res = {32'd0, res32}; o.hi = {32'd0, hi32};
            o.zero = z32; o.ovf = ov32; o.cond = cj32; o.dbz = dz32;
            bsy = busy32; dn = done32;
        end else begin
            o.res = {56'd0, res8}; o.hi = {56'd0, hi8};
            o.zero = z8; o.ovf = ov8; o.cond = cj8; o.dbz = dz8;
            bsy = busy8; dn = done8;
        end
        o.lat = 0;
    endtask

    // Issue one op, wait (bounded) for done, check latency, busy span,
    // results, the one-cycle done pulse and result hold afterwards.
    task automatic run_and_check(input string name, input int w, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b, input exp_t e);
        exp_t o;
        logic bsy, dn;
        int   lat, bcnt;
        @(negedge clk);
        rst = 1'b0;
        drive(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, op, a, b);
        lat  = 1;
        bcnt = 0;
        sample(w, o, bsy, dn);
        while (!dn && lat < 200) begin
            bcnt += int'(bsy);
            @(posedge clk);
            #1;
            lat++;
            sample(w, o, bsy, dn);
        end
        bcnt += int'(bsy);
        check({name, ".latency"}, 64'(lat), 64'(e.lat));
        check({name, ".busy_cycles"}, 64'(bcnt), 64'(e.lat));
        check({name, ".alu_res"}, o.res, e.res);
        check({name, ".alu_hi"}, o.hi, e.hi);
        check({name, ".zero"}, 64'(o.zero), 64'(e.zero));
        check({name, ".overflow"}, 64'(o.ovf), 64'(e.ovf));
        check({name, ".condition_jdg"}, 64'(o.cond), 64'(e.cond));
        check({name, ".div_by_zero"}, 64'(o.dbz), 64'(e.dbz));
        @(posedge clk);
        #1;
        sample(w, o, bsy, dn);
        check({name, ".done_after"}, 64'(dn), 64'd0);
        check({name, ".busy_after"}, 64'(bsy), 64'd0);
        check({name, ".res_held"}, o.res, e.res);
    endtask

    vec_t tbl[$];

    initial begin
        exp_t        o, e;
        logic        bsy, dn;
        int          ndone, done_c;
        logic [63:0] ra, rb, first_res, first_hi;
        int          w;
        logic [3:0]  op;

        rst = 1'b1;
        drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
        drive(8, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        sample(32, o, bsy, dn);
        check("reset.busy32", 64'(bsy), 64'd0);
        check("reset.done32", 64'(dn), 64'd0);
        check("reset.res32", o.res, 64'd0);
        check("reset.hi32", o.hi, 64'd0);
        check("reset.flags32", {60'd0, o.zero, o.ovf, o.cond, o.dbz}, 64'd0);
        sample(8, o, bsy, dn);
        check("reset.busy8", 64'(bsy), 64'd0);
        check("reset.res8", o.res, 64'd0);

        //            name          w   op     A              B              res            hi             z     o     c     d     lat
        tbl.push_back(mk("addi_ovf",   32, 4'd4,  64'h7FFFFFFF,  64'd1,         64'h80000000,  64'd0,         1'b0, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk("add_noflag", 32, 4'd0,  64'h7FFFFFFF,  64'd1,         64'h80000000,  64'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("mulu_max",   32, 4'd9,  64'hFFFFFFFF,  64'hFFFFFFFF,  64'h00000001,  64'hFFFFFFFE,  1'b1, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk("divu_100_7", 32, 4'd10, 64'd100,       64'd7,         64'd14,        64'd2,         1'b0, 1'b0, 1'b0, 1'b0, 33));
        tbl.push_back(mk("divu_by0",   32, 4'd10, 64'd5,         64'd0,         64'hFFFFFFFF,  64'd5,         1'b0, 1'b0, 1'b0, 1'b1, 1));
        tbl.push_back(mk("slt_neg",    32, 4'd3,  64'hFFFFFFFF,  64'd1,         64'd1,         64'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("sltu_big",   32, 4'd8,  64'd1,         64'hFFFFFFFF,  64'd1,         64'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("sub_eq",     32, 4'd1,  64'd5,         64'd5,         64'd0,         64'd0,         1'b1, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("bgezal_0",   32, 4'd5,  64'd0,         64'd5,         64'd0,         64'd0,         1'b0, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk("bgezal_neg", 32, 4'd5,  64'h80000000,  64'd0,         64'd0,         64'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("mulu8",      8,  4'd9,  64'hFF,        64'h02,        64'hFE,        64'h01,        1'b0, 1'b0, 1'b0, 1'b0, 9));
        tbl.push_back(mk("illegal8",   8,  4'd15, 64'h03,        64'h03,        64'd0,         64'd0,         1'b0, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk("divu8",      8,  4'd10, 64'd200,       64'd13,        64'd15,        64'd5,         1'b0, 1'b0, 1'b0, 1'b0, 9));
        tbl.push_back(mk("divu8_by0",  8,  4'd10, 64'hFF,        64'd0,         64'hFF,        64'hFF,        1'b0, 1'b0, 1'b0, 1'b1, 1));

        foreach (tbl[i]) run_and_check(tbl[i].name, tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);

        // start held high through a divide (and its done cycle) while A/B wander.
        @(negedge clk);
        drive(32, 1'b1, 4'd10, 64'd100, 64'd7);
        ndone = 0; done_c = -1; first_res = '0; first_hi = '0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (done32) begin
                ndone++;
                if (ndone == 1) begin
                    done_c = c; first_res = {32'd0, res32}; first_hi = {32'd0, hi32};
                end
            end
            @(negedge clk);
            if (ndone == 0 || c == done_c) drive(32, 1'b1, 4'd10, 64'($urandom), 64'($urandom));
            else                           drive(32, 1'b0, 4'd10, 64'd0, 64'd0);
        end
        check("held_start.done_count", 64'(ndone), 64'd1);
        check("held_start.done_cycle", 64'(done_c), 64'd33);
        check("held_start.alu_res", first_res, 64'd14);
        check("held_start.alu_hi", first_hi, 64'd2);
        check("held_start.res_held", {32'd0, res32}, 64'd14);

        // Reset in the middle of a multiply abandons it.
        run_and_check("add_pre", 32, 4'd0, 64'd1, 64'd1, model(32, 4'd0, 64'd1, 64'd1));
        @(negedge clk);
        drive(32, 1'b1, 4'd9, 64'hFFFFFFFF, 64'h12345);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 4'd9, 64'hFFFFFFFF, 64'h12345);
        repeat (9) @(posedge clk);
        #1;
        check("mid_rst.busy_before", 64'(busy32), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sample(32, o, bsy, dn);
        check("mid_rst.busy", 64'(bsy), 64'd0);
        check("mid_rst.done", 64'(dn), 64'd0);
        check("mid_rst.res", o.res, 64'd0);
        check("mid_rst.hi", o.hi, 64'd0);
        run_and_check("post_rst_slt", 32, 4'd3, 64'hFFFFFFFF, 64'd1,
                      model(32, 4'd3, 64'hFFFFFFFF, 64'd1));

        // Random ops on both widths.
        for (int i = 0; i < 60; i++) begin
            w  = (i % 3 == 0) ? 8 : 32;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            ra = 64'($urandom) & ((64'd1 << w) - 64'd1);
            case ($urandom_range(0, 7))
                0:       rb = 64'd0;
                1:       rb = ra;
                2:       rb = (64'd1 << (w - 1)) - 64'd1;
                default: rb = 64'($urandom) & ((64'd1 << w) - 64'd1);
            endcase
            e = model(w, op, ra, rb);
            run_and_check($sformatf("rand%0d_w%0d_op%0d", i, w, op), w, op, ra, rb, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
